// File: rtl/cam_array_if.sv
// cam_array_if: port bundle between the associative-processor controller and a cam_array column.
interface cam_array_if #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512
);
  localparam int AW = $clog2(CELL_QUANT + 1);
  logic [AW-1:0]         addr_in;
  logic [CELL_QUANT-1:0] cell_wea_ctrl_ap;
  logic                  sel_internal_col;
  logic                  cam_mode;
  logic [WORD_SIZE-1:0]  data_in;
  logic                  op_direction;
  logic [WORD_SIZE-1:0]  key_a;
  logic [WORD_SIZE-1:0]  key_b;
  logic [WORD_SIZE-1:0]  mask_a;
  logic [WORD_SIZE-1:0]  mask_b;
  logic                  write_en;
  logic [CELL_QUANT-1:0] tags;
  logic [WORD_SIZE-1:0]  data_out;
  modport master (
    output addr_in, cell_wea_ctrl_ap, sel_internal_col, cam_mode, data_in, op_direction,
           key_a, key_b, mask_a, mask_b, write_en,
    input  tags, data_out
  );
  modport slave (
    input  addr_in, cell_wea_ctrl_ap, sel_internal_col, cam_mode, data_in, op_direction,
           key_a, key_b, mask_a, mask_b, write_en,
    output tags, data_out
  );
endinterface

// File: rtl/cam_array.sv
// cam_array: bit-maskable CAM column; addressed RAM in normal mode, parallel masked search/write in AP mode.
module cam_array #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512
) (
  input  logic        clock,
  input  logic        rst,
  cam_array_if.slave  bus
);
  localparam int AW = $clog2(CELL_QUANT + 1);
  localparam int IW = CELL_QUANT > 1 ? $clog2(CELL_QUANT) : 1;
  logic [CELL_QUANT-1:0][WORD_SIZE-1:0] mem, key_sel, mask_sel;
  logic in_range;
  assign in_range = bus.addr_in < AW'(CELL_QUANT);
  assign bus.data_out = in_range ? mem[bus.addr_in[IW-1:0]] : '0;
  // horizontal mode alternates key/mask pairs by word parity
  always_comb begin
    for (int i = 0; i < CELL_QUANT; i++) begin
      key_sel[i]  = (bus.op_direction && (i[0] != bus.sel_internal_col)) ? bus.key_b : bus.key_a;
      mask_sel[i] = (bus.op_direction && (i[0] != bus.sel_internal_col)) ? bus.mask_b : bus.mask_a;
      bus.tags[i] = ((mem[i] ^ key_sel[i]) & mask_sel[i]) == '0;
    end
  end
  always_ff @(posedge clock) begin
    if (rst) mem <= '0;
    else
      for (int i = 0; i < CELL_QUANT; i++)
        if (bus.cam_mode ? bus.cell_wea_ctrl_ap[i] : (bus.write_en && bus.addr_in == AW'(i)))
          mem[i] <= bus.cam_mode ? (mem[i] & ~mask_sel[i]) | (bus.data_in & mask_sel[i]) : bus.data_in;
  end
endmodule

// File: tb/tb_cam_array.sv
// tb_cam_array: table-driven RAM vectors, directed AP sequences and randomized checks against a word-array model.
module tb_cam_array;
  localparam int W = 8;
  localparam int N = 512;
  logic clock, rst;
  int checks = 0, errors = 0;
  logic [W-1:0] model [N];
  cam_array_if #(.WORD_SIZE(W), .CELL_QUANT(N)) bus ();
  cam_array #(.WORD_SIZE(W), .CELL_QUANT(N)) dut (.clock(clock), .rst(rst), .bus(bus));
  initial clock = 0;
  always #5 clock = ~clock;
  typedef struct {
    logic [9:0]   addr;
    logic [W-1:0] data;
    logic         we;
    logic [W-1:0] exp;
  } ram_vec_t;
  ram_vec_t vt [7];
  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic alt(int i);
    return bus.op_direction && ((i % 2) != int'(bus.sel_internal_col));
  endfunction
  function automatic logic [W-1:0] msk(int i);
    return alt(i) ? bus.mask_b : bus.mask_a;
  endfunction
  function automatic logic [W-1:0] key(int i);
    return alt(i) ? bus.key_b : bus.key_a;
  endfunction
  function automatic logic [N-1:0] model_tags();
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) t[i] = ((model[i] ^ key(i)) & msk(i)) == 0;
    return t;
  endfunction
  function automatic logic [W-1:0] model_read();
    return (int'(bus.addr_in) < N) ? model[int'(bus.addr_in)] : '0;
  endfunction
  task automatic step();
    logic [W-1:0] nxt [N];
    nxt = model;
    if (rst) for (int i = 0; i < N; i++) nxt[i] = '0;
    else if (bus.cam_mode) begin
      for (int i = 0; i < N; i++)
        if (bus.cell_wea_ctrl_ap[i]) nxt[i] = (model[i] & ~msk(i)) | (bus.data_in & msk(i));
    end else if (bus.write_en && int'(bus.addr_in) < N) nxt[int'(bus.addr_in)] = bus.data_in;
    @(posedge clock);
    #1;
    model = nxt;
  endtask
  task automatic idle();
    bus.addr_in = '0; bus.cell_wea_ctrl_ap = '0; bus.sel_internal_col = 0; bus.cam_mode = 0;
    bus.data_in = '0; bus.op_direction = 0; bus.key_a = '0; bus.key_b = '0;
    bus.mask_a = '0; bus.mask_b = '0; bus.write_en = 0;
  endtask
  task automatic write_ram(int a, logic [W-1:0] d);
    bus.cam_mode = 0; bus.addr_in = 10'(a); bus.data_in = d; bus.write_en = 1;
    step();
    bus.write_en = 0;
  endtask
  task automatic rd(string name, int a, logic [W-1:0] exp);
    bus.addr_in = 10'(a);
    #1;
    check(name, N'(bus.data_out), N'(exp));
  endtask
  task automatic check_model();
    #1;
    check("model_tags", bus.tags, model_tags());
    check("model_data_out", N'(bus.data_out), N'(model_read()));
  endtask
  initial begin
    vt[0] = '{10'd5,   8'hA5, 1'b1, 8'hA5};
    vt[1] = '{10'd511, 8'h3C, 1'b1, 8'h3C};
    vt[2] = '{10'd6,   8'h77, 1'b0, 8'h00};
    vt[3] = '{10'd600, 8'hFF, 1'b1, 8'h00};
    vt[4] = '{10'd5,   8'h00, 1'b0, 8'hA5};
    vt[5] = '{10'd511, 8'h11, 1'b0, 8'h3C};
    vt[6] = '{10'd1023,8'hEE, 1'b1, 8'h00};
    for (int i = 0; i < N; i++) model[i] = '0;
    idle();
    rst = 1;
    step();
    rst = 0;
    #1;
    check("reset_data_out", N'(bus.data_out), '0);
    check("reset_tags_mask0", bus.tags, '1);
    bus.mask_a = 8'hFF;
    #1;
    check("reset_tags_key0", bus.tags, '1);
    bus.key_a = 8'h01; bus.mask_a = 8'h01;
    #1;
    check("reset_tags_key1", bus.tags, '0);
    idle();
    for (int v = 0; v < 7; v++) begin
      bus.cam_mode = 0; bus.addr_in = vt[v].addr; bus.data_in = vt[v].data; bus.write_en = vt[v].we;
      step();
      bus.write_en = 0;
      #1;
      check($sformatf("ram_vec%0d", v), N'(bus.data_out), N'(vt[v].exp));
    end
    rst = 1;
    step();
    rst = 0;
    write_ram(0, 8'h01); write_ram(1, 8'h02); write_ram(2, 8'h03); write_ram(3, 8'h00);
    bus.cam_mode = 1; bus.op_direction = 0; bus.key_a = 8'h01; bus.mask_a = 8'h01;
    #1;
    check("vert_tags", bus.tags, N'(4'b0101));
    bus.mask_a = 8'h00;
    #1;
    check("vert_tags_mask0", bus.tags, '1);
    bus.cell_wea_ctrl_ap = N'(4'b0110); bus.mask_a = 8'h80; bus.data_in = 8'h80;
    step();
    bus.cell_wea_ctrl_ap = '0;
    rd("apw_mem0", 0, 8'h01); rd("apw_mem1", 1, 8'h82);
    rd("apw_mem2", 2, 8'h83); rd("apw_mem3", 3, 8'h00);
    write_ram(0, 8'h04); write_ram(1, 8'h08);
    bus.op_direction = 1; bus.sel_internal_col = 0;
    bus.key_a = 8'h04; bus.mask_a = 8'h04; bus.key_b = 8'h08; bus.mask_b = 8'h08;
    #1;
    check("horiz_sel0", N'(bus.tags[1:0]), N'(2'b11));
    bus.sel_internal_col = 1;
    #1;
    check("horiz_sel1", N'(bus.tags[1:0]), N'(2'b00));
    idle();
    bus.cam_mode = 1; bus.write_en = 1; bus.addr_in = 10'd7; bus.data_in = 8'hFF;
    step();
    idle();
    rd("iso_ap_mem7", 7, 8'h00);
    bus.cell_wea_ctrl_ap = '1; bus.data_in = 8'hFF; bus.mask_a = 8'hFF;
    step();
    bus.cell_wea_ctrl_ap = '0;
    rd("iso_ram_mem0", 0, 8'h04); rd("iso_ram_mem1", 1, 8'h08); rd("iso_ram_mem2", 2, 8'h83);
    bus.cam_mode = 1; bus.cell_wea_ctrl_ap = '1; bus.data_in = 8'hFF; bus.mask_a = 8'hFF;
    rst = 1;
    step();
    rst = 0;
    bus.cell_wea_ctrl_ap = '0; bus.key_a = 8'h00;
    #1;
    check("rst_mid_tags", bus.tags, '1);
    rd("rst_mid_mem1", 1, 8'h00); rd("rst_mid_mem2", 2, 8'h00);
    for (int it = 0; it < 300; it++) begin
      logic [N-1:0] w1, w2;
      for (int k = 0; k < N / 32; k++) begin
        w1[k*32 +: 32] = $urandom;
        w2[k*32 +: 32] = $urandom;
      end
      bus.cell_wea_ctrl_ap = w1 & w2;
      bus.cam_mode = 1'($urandom_range(0, 1));
      bus.op_direction = 1'($urandom_range(0, 1));
      bus.sel_internal_col = 1'($urandom_range(0, 1));
      bus.key_a = 8'($urandom); bus.key_b = 8'($urandom);
      bus.mask_a = 8'($urandom); bus.mask_b = 8'($urandom);
      bus.data_in = 8'($urandom);
      bus.write_en = 1'($urandom_range(0, 1));
      bus.addr_in = 10'($urandom_range(0, 700));
      rst = ($urandom_range(0, 59) == 0);
      check_model();
      step();
      rst = 0;
      check_model();
    end
    idle();
    for (int a = 0; a < N; a++) begin
      bus.addr_in = 10'(a);
      #1;
      if (bus.data_out !== model[a]) check($sformatf("sweep_%0d", a), N'(bus.data_out), N'(model[a]));
      else checks++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cam_array.md
Name: cam_array

Overview:
- Bit-maskable content-addressable memory of CELL_QUANT words, each WORD_SIZE bits; one instance per operand column (A, B, C) of the associative processor.
- Normal mode: ordinary addressed RAM (single-word write, asynchronous read).
- AP mode: every word is compared in parallel against a masked key, producing a per-word tag vector. Tagged words selected by the controller's write-enable vector receive a masked parallel write.

Parameters:
- WORD_SIZE, 8, bits per cell word.
- CELL_QUANT, 512, number of cell words.
- AW (derived, not overridable), bit count of CELL_QUANT (floor(log2)+1; 10 for 512), address width.

Ports:
- clock  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- addr_in  in  AW  word address for normal-mode read/write.
- cell_wea_ctrl_ap  in  CELL_QUANT  per-word parallel write enable (AP mode).
- sel_internal_col  in  1  horizontal-mode key/mask parity select.
- cam_mode  in  1  0 = RAM mode, 1 = AP mode.
- data_in  in  WORD_SIZE  write data.
- op_direction  in  1  0 = vertical, 1 = horizontal.
- key_a  in  WORD_SIZE  primary search key.
- key_b  in  WORD_SIZE  secondary search key (horizontal).
- mask_a  in  WORD_SIZE  primary bit mask (1 = bit participates).
- mask_b  in  WORD_SIZE  secondary bit mask.
- write_en  in  1  normal-mode single-word write strobe.
- tags  out  CELL_QUANT  per-word match flags.
- data_out  out  WORD_SIZE  word at addr_in.

Behaviour:
- Storage: mem[0..CELL_QUANT-1], WORD_SIZE bits each.
- Reset: on a rising edge with rst=1, all words cleared to 0; no write occurs that cycle. After reset, data_out = 0, and tags = all-ones where the selected mask is 0 or key = 0.
- Key/mask select per word i:
  - op_direction=0: key_a/mask_a for all words.
  - op_direction=1: key_a/mask_a when i[0]==sel_internal_col, else key_b/mask_b.
- Tags are combinational and always driven, in either mode: tags[i] = ((mem[i] XOR key_sel) AND mask_sel) == 0.
  - Mask of 0 gives tag 1.
  - Tags reflect memory contents after the most recent clock edge.
- data_out is combinational: mem[addr_in] if addr_in < CELL_QUANT, else 0. No read enable; the consumer registers it.
- cam_mode=0 writes: on a rising edge with write_en=1 and addr_in < CELL_QUANT, mem[addr_in] <= data_in (full word). Out-of-range addresses are ignored. cell_wea_ctrl_ap is ignored.
- cam_mode=1 writes: on a rising edge, for every i with cell_wea_ctrl_ap[i]=1, mem[i] <= (mem[i] AND NOT mask_sel) OR (data_in AND mask_sel), with mask_sel chosen per word as above. Unmasked bits are preserved. write_en is ignored.
- All written words update simultaneously on the same edge. Compare and write within one cycle use pre-edge contents (read-before-write).
- rst has priority over any write, including mid-AP-operation: memory cleared, operation lost.
- Mode switches take effect on the next edge; no internal state other than mem.

Test Plan:
- Reset then RAM write/read: rst 1 cycle; write addr 5 = 0xA5, addr 511 = 0x3C; read addr 5 -> 0xA5, addr 511 -> 0x3C, addr 6 -> 0x00; write to addr 600 -> no change, read addr 600 -> 0x00.
- Vertical search: mem[0..3] = 0x01,0x02,0x03,0x00; cam_mode=1, op_direction=0, key_a=0x01, mask_a=0x01 -> tags[3:0]=0101, all other tags 0 (remaining words hold 0, bit0 = 0 ≠ key). mask_a=0x00 -> all tags 1.
- Masked parallel write: mem[0..3] as above; cell_wea_ctrl_ap=...0110, mask_a=0x80, data_in=0x80, one edge -> mem[1]=0x82, mem[2]=0x83, mem[0]=0x01, mem[3]=0x00 unchanged.
- Horizontal search: mem[0]=0x04, mem[1]=0x08; op_direction=1, sel_internal_col=0, key_a=0x04/mask_a=0x04, key_b=0x08/mask_b=0x08 -> tags[1:0]=11. sel_internal_col=1 -> tags[1:0]=00.
- Mode isolation: cam_mode=1, write_en=1, addr 7, data 0xFF, cell_wea_ctrl_ap=0 -> mem[7] unchanged. cam_mode=0, cell_wea_ctrl_ap=all-ones, write_en=0 -> nothing written.
- Reset mid-operation: after AP writes, assert rst alongside cell_wea_ctrl_ap=all-ones, data_in=0xFF, mask_a=0xFF -> all words 0, data_out 0.
